// File: rtl/hello_pkg.sv
// Shared types and constants for the scrolling "HELLO____" message sequencer.
// Message ring is 9 entries; letter codes are 1..9 and 0 blanks a decoder.
// Pure definitions: no timing, no flow control.
package hello_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int MSG_LEN = 9;

    localparam logic [3:0] CODE_OFF   = 4'd0;
    localparam logic [3:0] CODE_H     = 4'd1;
    localparam logic [3:0] CODE_E     = 4'd2;
    localparam logic [3:0] CODE_L     = 4'd3;
    localparam logic [3:0] CODE_L2    = 4'd4;
    localparam logic [3:0] CODE_O     = 4'd5;
    localparam logic [3:0] CODE_BLANK = 4'd6;

    localparam logic [3:0] POS_LAST = 4'(MSG_LEN - 1);

    // Ring position after one scroll step; dir=0 moves left (increment).
    function automatic logic [3:0] pos_step(input logic [3:0] pos, input logic dir);
        if (!dir) begin
            return (pos == POS_LAST) ? 4'd0 : pos + 4'd1;
        end
        return (pos == 4'd0) ? POS_LAST : pos - 4'd1;
    endfunction

    // Letter code stored at a ring index; the four trailing blanks use codes 6..9.
    function automatic logic [3:0] msg_code(input logic [3:0] idx);
        case (idx)
            4'd0:    return CODE_H;
            4'd1:    return CODE_E;
            4'd2:    return CODE_L;
            4'd3:    return CODE_L2;
            4'd4:    return CODE_O;
            4'd5:    return CODE_BLANK;
            4'd6:    return CODE_BLANK + 4'd1;
            4'd7:    return CODE_BLANK + 4'd2;
            4'd8:    return CODE_BLANK + 4'd3;
            default: return CODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/hello_scroller_if.sv
// Control/status bundle between board controls and the scroll sequencer.
// Master drives start/stop/pause/dir; slave returns codes, wrap and busy.
// No handshake: controls are pulses/levels, status is registered state.
interface hello_scroller_if #(
    parameter int NUM_DIGITS = 5
);
    logic                      start;
    logic                      stop;
    logic                      pause;
    logic                      dir;
    logic [4*NUM_DIGITS-1:0]   codes;
    logic                      wrap;
    logic                      busy;

    modport master (
        output start, stop, pause, dir,
        input  codes, wrap, busy
    );

    modport slave (
        input  start, stop, pause, dir,
        output codes, wrap, busy
    );
endinterface

// File: rtl/scroll_prescaler.sv
// Divides the clock into one step strobe every TICK_DIV cycles of run.
// Latency: step is combinational from the registered count, no extra delay.
// No backpressure: holding run low freezes the count, clear zeroes it.
module scroll_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic step
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign step = run && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = step ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/hello_scroller.sv
// Scrolls "HELLO____" across NUM_DIGITS letter decoders, one step per TICK_DIV cycles.
// Latency: controls take effect on the next edge; codes decode from registered state.
// No backpressure: start/stop are pulses, pause is a level that freezes scrolling.
module hello_scroller
    import hello_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    hello_scroller_if.slave   bus
);
    state_e     state_q, state_d;
    logic [3:0] pos_q,   pos_d;
    logic       wrap_q,  wrap_d;
    logic       busy_q,  busy_d;
    logic       step;
    logic       clear;
    logic       wraps;

    // Any start or stop restarts the interval, whatever state we are in.
    assign clear = bus.start || bus.stop;

    scroll_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .run   (state_q == RUN),
        .step  (step)
    );

    assign wraps = bus.dir ? (pos_q == 4'd0) : (pos_q == POS_LAST);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
            pos_d   = 4'd0;
        end else if (bus.start) begin
            state_d = RUN;
            pos_d   = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (step) begin
                        pos_d  = pos_step(pos_q, bus.dir);
                        wrap_d = wraps;
                    end
                    if (bus.pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (!bus.pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= 4'd0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    // Digit k shows ring entry (pos+k) mod 9; the sum never exceeds 16.
    always_comb begin
        logic [4:0] sum;
        logic [3:0] idx;
        bus.codes = '0;
        sum       = '0;
        idx       = '0;
        if (state_q != IDLE) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                sum = {1'b0, pos_q} + 5'(k);
                idx = (sum >= 5'(MSG_LEN)) ? 4'(sum - 5'(MSG_LEN)) : sum[3:0];
                bus.codes[4*k +: 4] = msg_code(idx);
            end
        end
    end

    assign bus.wrap = wrap_q;
    assign bus.busy = busy_q;
endmodule
